// File: rtl/register_file_2r1w.sv
// register_file_2r1w
//   Register bank between decode and writeback. It has one write port and two
//   registered read ports. The read ports bypass a same-cycle write. A
//   per-register pending scoreboard tracks outstanding producers. A sequential
//   soft-clear engine zeroes one register per cycle.
//
//   Optional build macro: REGFILE_ZERO_REG_EN
//     When defined, register 0 is hardwired to zero. Writes and marks to
//     address 0 are dropped, and reads of address 0 return zero data with the
//     pending bit clear.
//
//   Ports
//     clock, reset          rising-edge clock; synchronous active-low reset
//     wr_en/wr_addr/wr_data write port (also clears the pending bit)
//     rd_en, rd_addr_a/b    read request; both ports sample together
//     rd_data_a/b, pend_a/b registered read results (1-cycle latency)
//     rd_valid              results above were updated this cycle
//     mark_en, mark_addr    set the pending bit of a register
//     clr_req               1-cycle pulse starts a soft clear
//     clr_busy              soft clear in progress
module register_file_2r1w #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_a,
  output logic [WIDTH-1:0]  rd_data_b,
  output logic              pend_a,
  output logic              pend_b,
  output logic              rd_valid,
  input  logic              mark_en,
  input  logic [ADDR_W-1:0] mark_addr,
  input  logic              clr_req,
  output logic              clr_busy
);

  localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0]  PTR_LAST = IDX_W'(DEPTH - 1);

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   ptr, ptr_nxt;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]   pend;

  logic               busy, wr_ok, mark_ok, rd_ok;
  logic [WIDTH-1:0]   rd_data_a_p0, rd_data_b_p0;
  logic               pend_a_p0, pend_b_p0;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_L;
  endfunction

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  function automatic logic writable(input logic [ADDR_W-1:0] a);
    return in_range(a) && !is_zero_reg(a);
  endfunction

  function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_W-1:0] a);
    return a[IDX_W-1:0];
  endfunction

  // Read data as it stands after this edge's write (write-to-read bypass).
  function automatic logic [WIDTH-1:0] read_data(input logic [ADDR_W-1:0] a);
    if (!in_range(a) || is_zero_reg(a)) return '0;
    if (wr_ok && (wr_addr == a))        return wr_data;
    return mem[to_idx(a)];
  endfunction

  // Pending bit after this edge's update; a mark beats a write (new producer wins).
  function automatic logic read_pend(input logic [ADDR_W-1:0] a);
    if (!in_range(a) || is_zero_reg(a)) return 1'b0;
    if (mark_ok && (mark_addr == a))    return 1'b1;
    if (wr_ok && (wr_addr == a))        return 1'b0;
    return pend[to_idx(a)];
  endfunction

  assign busy     = (state == CLEAR);
  assign clr_busy = busy;
  assign wr_ok    = wr_en   && !busy && writable(wr_addr);
  assign mark_ok  = mark_en && !busy && writable(mark_addr);
  assign rd_ok    = rd_en   && !busy;

  assign rd_data_a_p0 = read_data(rd_addr_a);
  assign rd_data_b_p0 = read_data(rd_addr_b);
  assign pend_a_p0    = read_pend(rd_addr_a);
  assign pend_b_p0    = read_pend(rd_addr_b);

  // Soft-clear FSM state register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt = CLEAR;
          ptr_nxt   = '0;
        end
      end
      CLEAR: begin
        ptr_nxt = ptr + 1'b1;
        if (ptr == PTR_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Storage update and p0 -> registered read outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      pend      <= '0;
      rd_data_a <= '0;
      rd_data_b <= '0;
      pend_a    <= 1'b0;
      pend_b    <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      if (busy) begin
        mem[ptr]  <= '0;
        pend[ptr] <= 1'b0;
      end else begin
        if (wr_ok) begin
          mem[to_idx(wr_addr)]  <= wr_data;
          pend[to_idx(wr_addr)] <= 1'b0;
        end
        // Placed after the write so a same-address mark takes priority.
        if (mark_ok) pend[to_idx(mark_addr)] <= 1'b1;
      end
      rd_valid <= rd_ok;
      if (rd_ok) begin
        rd_data_a <= rd_data_a_p0;
        rd_data_b <= rd_data_b_p0;
        pend_a    <= pend_a_p0;
        pend_b    <= pend_b_p0;
      end
    end
  end

endmodule

// File: tb/tb_register_file_2r1w.sv
module tb_register_file_2r1w;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;   // wider than needed so addresses >= DEPTH are exercised
  localparam int DEPTH  = 16;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic              wr_en, rd_en, mark_en, clr_req;
  logic [ADDR_W-1:0] wr_addr, rd_addr_a, rd_addr_b, mark_addr;
  logic [WIDTH-1:0]  wr_data;
  logic [WIDTH-1:0]  rd_data_a, rd_data_b;
  logic              pend_a, pend_b, rd_valid, clr_busy;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [WIDTH-1:0] m_mem [DEPTH];
  bit               m_pend [DEPTH];
  int               busy_left = 0;
  logic [WIDTH-1:0] e_a = '0, e_b = '0;
  bit               e_pa = 0, e_pb = 0, e_vld = 0;

  register_file_2r1w #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .pend_a(pend_a), .pend_b(pend_b), .rd_valid(rd_valid),
    .mark_en(mark_en), .mark_addr(mark_addr),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_writable(input int a);
    return (a < DEPTH) && !(ZERO_REG && a == 0);
  endfunction

  function automatic logic [WIDTH-1:0] m_rd(input int a);
    return (a < DEPTH) ? m_mem[a] : '0;
  endfunction

  function automatic bit m_rp(input int a);
    return (a < DEPTH) ? m_pend[a] : 1'b0;
  endfunction

  task automatic m_zero();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 0;
    end
  endtask

  // Apply this edge's effect to the model. A read sees the array after the
  // write/mark, which is exactly what the bypass promises.
  task automatic model_edge();
    if (!reset) begin
      m_zero();
      busy_left = 0;
      e_a = '0; e_b = '0; e_pa = 0; e_pb = 0; e_vld = 0;
    end else if (busy_left > 0) begin
      busy_left--;
      e_vld = 0;
    end else begin
      if (wr_en && m_writable(int'(wr_addr))) begin
        m_mem[wr_addr]  = wr_data;
        m_pend[wr_addr] = 0;
      end
      if (mark_en && m_writable(int'(mark_addr))) m_pend[mark_addr] = 1;
      e_vld = rd_en;
      if (rd_en) begin
        e_a  = m_rd(int'(rd_addr_a));
        e_b  = m_rd(int'(rd_addr_b));
        e_pa = m_rp(int'(rd_addr_a));
        e_pb = m_rp(int'(rd_addr_b));
      end
      // Internal state is unobservable during the clear, so the model erases
      // everything at once and just counts the busy window.
      if (clr_req) begin
        m_zero();
        busy_left = DEPTH;
      end
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clock);
    #1;
    check("rd_valid",  rd_valid,  e_vld);
    check("rd_data_a", rd_data_a, e_a);
    check("rd_data_b", rd_data_b, e_b);
    check("pend_a",    pend_a,    e_pa);
    check("pend_b",    pend_b,    e_pb);
    check("clr_busy",  clr_busy,  busy_left > 0);
  endtask

  task automatic quiet();
    reset = 1'b1; wr_en = 0; rd_en = 0; mark_en = 0; clr_req = 0;
  endtask

  task automatic rd2(input int a, input int b);
    quiet();
    rd_en = 1; rd_addr_a = ADDR_W'(a); rd_addr_b = ADDR_W'(b);
    cycle();
  endtask

  task automatic wr(input int a, input logic [WIDTH-1:0] d);
    quiet();
    wr_en = 1; wr_addr = ADDR_W'(a); wr_data = d;
    cycle();
  endtask

  initial begin
    int n;
    quiet();
    reset = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr_a = '0; rd_addr_b = '0; mark_addr = '0;
    cycle();

    // 1: reset after writes clears everything
    quiet();
    for (int i = 0; i < 6; i++) wr(i + 3, $urandom);
    quiet(); reset = 1'b0; wr_en = 1; wr_addr = 5'd4; wr_data = 32'hFFFF0000; rd_en = 1;
    cycle();
    check("t1_valid", rd_valid, 1'b0);
    check("t1_busy",  clr_busy, 1'b0);
    check("t1_data",  rd_data_a, 32'h0);
    for (int i = 0; i < DEPTH; i += 2) begin
      rd2(i, i + 1);
      check("t1_rd_a", rd_data_a, 32'h0);
      check("t1_rd_b", rd_data_b, 32'h0);
    end

    // 2: write then read next cycle
    wr(5, 32'hDEADBEEF);
    rd2(5, 20);
    check("t2_rd_a",   rd_data_a, 32'hDEADBEEF);
    check("t2_oob_b",  rd_data_b, 32'h0);
    check("t2_valid",  rd_valid, 1'b1);
    quiet(); cycle();
    check("t2_hold",   rd_data_a, 32'hDEADBEEF);
    check("t2_novld",  rd_valid, 1'b0);

    // 3: same-cycle bypass on both ports
    quiet();
    wr_en = 1; wr_addr = 5'd3; wr_data = 32'h1234;
    rd_en = 1; rd_addr_a = 5'd3; rd_addr_b = 5'd3;
    cycle();
    check("t3_byp_a", rd_data_a, 32'h1234);
    check("t3_byp_b", rd_data_b, 32'h1234);

    // 4: scoreboard
    quiet(); mark_en = 1; mark_addr = 5'd7; cycle();
    rd2(7, 7);
    check("t4_pend_set", pend_a, 1'b1);
    rd2(7, 7);
    check("t4_pend_keep", pend_a, 1'b1);
    wr(7, 32'h55);
    rd2(7, 3);
    check("t4_pend_clr", pend_a, 1'b0);
    check("t4_data",     rd_data_a, 32'h55);
    quiet(); mark_en = 1; mark_addr = 5'd7; wr_en = 1; wr_addr = 5'd7; wr_data = 32'h66;
    cycle();
    rd2(7, 7);
    check("t4_mark_wins", pend_a, 1'b1);

    // 5: soft clear window, dropped writes, reset mid-clear
    for (int i = 0; i < DEPTH; i++) wr(i, 32'hA0000000 | i);
    quiet(); clr_req = 1; cycle();
    quiet(); wr_en = 1; mark_en = 1; clr_req = 1;
    n = 0;
    for (int k = 0; k < 40 && clr_busy; k++) begin
      n++;
      wr_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      mark_addr = wr_addr;
      wr_data = $urandom;
      rd_en = 1;
      cycle();
    end
    check("t5_busy_cycles", n, 16);
    for (int i = 0; i < DEPTH; i += 2) begin
      rd2(i, i + 1);
      check("t5_clr_a", rd_data_a, 32'h0);
      check("t5_clr_b", rd_data_b, 32'h0);
    end
    quiet(); clr_req = 1; cycle();
    quiet();
    for (int k = 0; k < 7; k++) cycle();
    check("t5_mid_busy", clr_busy, 1'b1);
    reset = 1'b0; cycle();
    check("t5_rst_busy", clr_busy, 1'b0);

    // 6: register 0
    wr(0, 32'hFFFFFFFF);
    rd2(0, 0);
    check("t6_r0", rd_data_a, ZERO_REG ? 32'h0 : 32'hFFFFFFFF);

    // Randomized traffic against the model
    for (int k = 0; k < 500; k++) begin
      reset     = ($urandom_range(0, 99) != 0);
      wr_en     = $urandom_range(0, 1);
      wr_addr   = ADDR_W'($urandom_range(0, 19));
      wr_data   = $urandom;
      mark_en   = ($urandom_range(0, 3) == 0);
      mark_addr = ($urandom_range(0, 1) == 0) ? wr_addr : ADDR_W'($urandom_range(0, 19));
      rd_en     = $urandom_range(0, 1);
      rd_addr_a = ($urandom_range(0, 2) == 0) ? wr_addr : ADDR_W'($urandom_range(0, 19));
      rd_addr_b = ($urandom_range(0, 2) == 0) ? mark_addr : ADDR_W'($urandom_range(0, 19));
      clr_req   = ($urandom_range(0, 39) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
